// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and counter-width defaults for the debouncer
package debounce_pkg;

  typedef enum logic [1:0] {zero, wait0, one, wait1} state_t;

  localparam int CNT_W_SYNTH = 20;
  localparam int CNT_W_SIM   = 2;

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debouncer channel: synchroniser, filter FSM and down-counter
// Optional auto-repeat counter built when DEBOUNCE_MULTI_REPEAT_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W       = CNT_W_SYNTH,
  parameter int SYNC_STAGES = 2,
  parameter int REP_W       = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic rep_tick
);

  localparam logic [CNT_W-1:0] CNT_LOAD = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign sw_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= zero;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ticks qualify on sw_s so a bounce landing on the last count cycle is still rejected.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rise_tick = 1'b0;
    fall_tick = 1'b0;
    unique case (state_q)
      zero: begin
        if (sw_s) begin
          state_d = wait1;
          cnt_d   = CNT_LOAD;
        end
      end
      wait1: begin
        if (!sw_s) begin
          state_d = zero;
        end else if (cnt_q == CNT_ONE) begin
          rise_tick = 1'b1;
          state_d   = one;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      one: begin
        if (!sw_s) begin
          state_d = wait0;
          cnt_d   = CNT_LOAD;
        end
      end
      wait0: begin
        if (sw_s) begin
          state_d = one;
        end else if (cnt_q == CNT_ONE) begin
          fall_tick = 1'b1;
          state_d   = zero;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = zero;
    endcase
  end

  assign db_level = (state_q == one) || (state_q == wait0);

`ifdef DEBOUNCE_MULTI_REPEAT_EN
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_tick_q, rep_tick_d;

  always_comb begin
    rep_d      = '0;
    rep_tick_d = 1'b0;
    if (state_q == one) begin
      rep_d      = rep_q + REP_W'(1);
      rep_tick_d = &rep_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q      <= '0;
      rep_tick_q <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      rep_tick_q <= rep_tick_d;
    end
  end

  assign rep_tick = rep_tick_q;
`else
  logic unused_rep_w;
  assign unused_rep_w = |REP_W;
  assign rep_tick     = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - NCH independent debouncer channels for board buttons and switches
// Auto-repeat ticks are produced only when DEBOUNCE_MULTI_REPEAT_EN is defined.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NCH         = 5,
  parameter int CNT_W       = CNT_W_SYNTH,
  parameter int SYNC_STAGES = 2,
  parameter int REP_W       = 26
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] rise_tick,
  output logic [NCH-1:0] fall_tick,
  output logic [NCH-1:0] rep_tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .REP_W      (REP_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw[i]),
      .db_level (db_level[i]),
      .rise_tick(rise_tick[i]),
      .fall_tick(fall_tick[i]),
      .rep_tick (rep_tick[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi (CNT_W=2, SYNC_STAGES=2, REP_W=3)
module tb_debounce_multi;

  localparam int NCH = 5;
`ifdef DEBOUNCE_MULTI_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] db_level;
  logic [NCH-1:0] rise_tick;
  logic [NCH-1:0] fall_tick;
  logic [NCH-1:0] rep_tick;

  debounce_multi #(
    .NCH        (NCH),
    .CNT_W      (2),
    .SYNC_STAGES(2),
    .REP_W      (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .rep_tick (rep_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic string kname(input int k);
    case (k)
      0:       return "rise_tick";
      1:       return "fall_tick";
      default: return "rep_tick";
    endcase
  endfunction

  task automatic push(input int c, input int k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  // Repeat pulses land every 8 cycles after entering one, while one is held.
  task automatic exp_hold(input int ch, input int r, input int w);
    if (REP_EN) begin
      for (int t = r + 8; t <= w; t += 8) push(t, 2, ch);
    end
  endtask

  task automatic match(input int kind, input int ch);
    int idx;
    idx = -1;
    checks++;
    foreach (exp_q[k]) begin
      if (idx < 0 && exp_q[k].cyc == cyc && exp_q[k].kind == kind && exp_q[k].ch == ch) idx = k;
    end
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected %s ch%0d at cycle %0d: got 1, required 0", kname(kind), ch, cyc);
    end else begin
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (rise_tick[ch]) match(0, ch);
        if (fall_tick[ch]) match(1, ch);
        if (rep_tick[ch])  match(2, ch);
      end
    end
  end

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_lvl(input int ch, input logic exp, input string nm);
    checks++;
    if (db_level[ch] !== exp) begin
      errors++;
      $display("FAIL %s: db_level[%0d] got %b, required %b at cycle %0d", nm, ch, db_level[ch], exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  initial begin
    int c, c2, c3;
    reset = 1'b1;
    sw    = '1;
    goto_cyc(3);
    chk_vec("reset db_level", db_level, '0);
    chk_vec("reset rise_tick", rise_tick, '0);
    chk_vec("reset fall_tick", fall_tick, '0);
    chk_vec("reset rep_tick", rep_tick, '0);

    // Release reset with only sw[0] high; also the 40-cycle hold for auto-repeat.
    c     = cyc;
    sw    = 5'b00001;
    reset = 1'b0;
    push(c + 5, 0, 0);
    goto_cyc(c + 5);
    chk_lvl(0, 1'b0, "first rise before level");
    goto_cyc(c + 6);
    chk_lvl(0, 1'b1, "first rise level");
    goto_cyc(c + 40);
    c2    = cyc;
    sw[0] = 1'b0;
    push(c2 + 5, 1, 0);
    exp_hold(0, c + 6, c2 + 3);
    goto_cyc(c2 + 5);
    chk_lvl(0, 1'b1, "hold release before level");
    goto_cyc(c2 + 6);
    chk_lvl(0, 1'b0, "hold release level");

    // Glitch of 3 cycles on sw[1] is rejected.
    goto_cyc(cyc + 2);
    c     = cyc;
    sw[1] = 1'b1;
    goto_cyc(c + 3);
    sw[1] = 1'b0;
    for (int t = c + 4; t <= c + 10; t += 2) begin
      goto_cyc(t);
      chk_lvl(1, 1'b0, "glitch 3 cycles");
    end

    // A 4-cycle pulse is the shortest accepted one.
    c     = cyc;
    sw[1] = 1'b1;
    push(c + 5, 0, 1);
    goto_cyc(c + 4);
    sw[1] = 1'b0;
    push(c + 9, 1, 1);
    exp_hold(1, c + 6, c + 7);
    goto_cyc(c + 6);
    chk_lvl(1, 1'b1, "4-cycle pulse level");
    goto_cyc(c + 10);
    chk_lvl(1, 1'b0, "4-cycle pulse drop");

    // Rise then stable release on sw[2].
    c     = cyc;
    sw[2] = 1'b1;
    push(c + 5, 0, 2);
    goto_cyc(c + 6);
    chk_lvl(2, 1'b1, "release pre level");
    c2    = cyc;
    sw[2] = 1'b0;
    push(c2 + 5, 1, 2);
    exp_hold(2, c + 6, c2 + 3);
    goto_cyc(c2 + 5);
    chk_lvl(2, 1'b1, "release 5 cycles");
    goto_cyc(c2 + 6);
    chk_lvl(2, 1'b0, "release 6 cycles");

    // Bounce on sw[3] during wait0, then a stable release.
    c     = cyc;
    sw[3] = 1'b1;
    push(c + 5, 0, 3);
    goto_cyc(c + 6);
    c2    = cyc;
    sw[3] = 1'b0;
    goto_cyc(c2 + 3);
    sw[3] = 1'b1;
    goto_cyc(c2 + 4);
    sw[3] = 1'b0;
    goto_cyc(c2 + 5);
    sw[3] = 1'b1;
    for (int t = c2 + 6; t <= c2 + 10; t++) begin
      goto_cyc(t);
      chk_lvl(3, 1'b1, "bounce in wait0");
    end
    c3    = cyc;
    sw[3] = 1'b0;
    push(c3 + 5, 1, 3);
    exp_hold(3, c + 6, c2 + 3);
    exp_hold(3, c2 + 6, c2 + 7);
    exp_hold(3, c2 + 8, c3 + 3);
    goto_cyc(c3 + 5);
    chk_lvl(3, 1'b1, "bounce full filter");
    goto_cyc(c3 + 6);
    chk_lvl(3, 1'b0, "bounce final drop");

    // sw[0] rises in the same cycle sw[4] falls.
    c     = cyc;
    sw[4] = 1'b1;
    push(c + 5, 0, 4);
    goto_cyc(c + 6);
    c2    = cyc;
    sw[0] = 1'b1;
    sw[4] = 1'b0;
    push(c2 + 5, 0, 0);
    push(c2 + 5, 1, 4);
    exp_hold(4, c + 6, c2 + 3);
    goto_cyc(c2 + 6);
    chk_lvl(0, 1'b1, "parallel ch0 level");
    chk_lvl(4, 1'b0, "parallel ch4 level");
    c3    = cyc;
    sw[0] = 1'b0;
    push(c3 + 5, 1, 0);
    exp_hold(0, c2 + 6, c3 + 3);
    goto_cyc(c3 + 6);
    chk_lvl(0, 1'b0, "parallel ch0 drop");

    // Reset in the middle of wait1 aborts the filter.
    c     = cyc;
    sw[1] = 1'b1;
    sw[2] = 1'b1;
    goto_cyc(c + 4);
    reset = 1'b1;
    sw    = '0;
    #1;
    chk_vec("mid-filter reset db_level", db_level, '0);
    chk_vec("mid-filter reset rise_tick", rise_tick, '0);
    chk_vec("mid-filter reset fall_tick", fall_tick, '0);
    goto_cyc(c + 6);
    reset = 1'b0;
    goto_cyc(c + 16);
    chk_vec("after mid-filter reset db_level", db_level, '0);

    goto_cyc(cyc + 6);
    foreach (exp_q[k]) begin
      checks++;
      errors++;
      $display("FAIL missed %s ch%0d at cycle %0d: got 0, required 1", kname(exp_q[k].kind), exp_q[k].ch, exp_q[k].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel debouncer for the Nexys A7-100T mechanical inputs (push-buttons, slide switches).
- Each channel has its own 2-FF synchroniser, zero/wait1/one/wait0 filter FSM and down-counter.
- Each channel produces a debounced level and single-cycle rise and fall ticks.
- Sits between the board I/O pins and the user logic; replaces per-button instances of the single-channel debouncer.

Parameters:
- NCH, 5, number of independent input channels (≥1).
- CNT_W, 20, filter counter width; stable time = 2^CNT_W cycles (20 → ~10.5 ms at 100 MHz; 2 in simulation).
- SYNC_STAGES, 2, synchroniser flip-flops per channel (≥2).
- REP_W, 26, auto-repeat period counter width (used only with the optional feature).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- sw  input  NCH  raw switch/button inputs, asynchronous to clk.
- db_level  output  NCH  debounced level per channel.
- rise_tick  output  NCH  1-cycle pulse on debounced 0→1.
- fall_tick  output  NCH  1-cycle pulse on debounced 1→0.
- rep_tick  output  NCH  auto-repeat pulse while held; constant 0 without the optional feature.

Behaviour:
- Reset clocking: reset (clk, asynchronous, active-high) forces everything to 0 immediately.
  - Cleared: sync regs, FSM state = zero, counters, db_level, rise_tick, fall_tick, rep_tick.
  - Reset mid-filter aborts the filter; no tick is emitted.
- Synchroniser: sw[i] passes through SYNC_STAGES FFs; the last stage is sw_s[i]. The FSM sees only sw_s.
- Per-channel FSM (channels fully independent, no shared counter):
  - zero: db_level=0. If sw_s=1: go to wait1 and load cnt = 2^CNT_W-1.
  - wait1: db_level=0.
    - sw_s=0: go to zero; cnt value is don't-care, reloaded on next entry.
    - sw_s=1: cnt decrements. In the cycle cnt==1, assert rise_tick and go to one.
  - one: db_level=1. If sw_s=0: go to wait0 and load cnt = 2^CNT_W-1.
  - wait0: db_level=1.
    - sw_s=1: go to one; no tick.
    - sw_s=0: cnt decrements. In the cycle cnt==1, assert fall_tick and go to zero.
- Timing:
  - rise_tick/fall_tick are combinational from registered state and cnt.
  - Each tick is high exactly one cycle, the cycle immediately before db_level changes.
  - A stable edge on sw changes db_level SYNC_STAGES + 2^CNT_W cycles later.
- Glitch rejection: an excursion of sw_s lasting ≤ 2^CNT_W-1 cycles produces no tick and no level change. Each bounce restarts the full count.
- Counter arithmetic: unsigned CNT_W bits; load value is all-ones. Decrement occurs only in wait states with the confirming input, so the counter never wraps.
- Ticks and state: rise_tick and fall_tick are never both high on one channel in the same cycle. Simultaneous events on different channels are independent.

Optional Feature:
- Macro: DEBOUNCE_MULTI_REPEAT_EN.
- Defined: each channel has a REP_W-bit repeat counter.
  - Counter is cleared whenever state ≠ one and increments every cycle in state one.
  - When it wraps from all-ones to 0, rep_tick[i] pulses for 1 cycle.
  - First rep_tick comes 2^REP_W cycles after db_level rises, then every 2^REP_W cycles while held.
  - A bounce to wait0 and back to one restarts the period.
- Not defined: rep_tick is tied to 0 and no repeat counters are synthesised.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] state_t {zero, wait0, one, wait1};
  - localparam defaults for CNT_W_SYNTH = 20 and CNT_W_SIM = 2.
- Sub-module debounce_chan: one channel containing the synchroniser, FSM, counter and optional repeat counter. Same parameters minus NCH; scalar ports.
- debounce_multi is a generate loop of NCH debounce_chan instances.

Test Plan (CNT_W=2, SYNC_STAGES=2, REP_W=3):
- Reset: hold reset with sw=all 1s → all outputs 0. After release, sw[0] held 1 → rise_tick[0] high for exactly 1 cycle at cycle 5; db_level[0]=1 from cycle 6.
- Glitch: sw[1] high for 3 cycles then 0 → db_level[1], rise_tick[1] and fall_tick[1] stay 0 throughout.
- Release: after db_level[2]=1, sw[2] set to 0 and held → fall_tick[2] pulses once; db_level[2]=0 six cycles after the sw change.
- Bounce during wait0: sw[3] toggles 1,0,1 with 1-cycle spacing while in wait0 → db_level[3] remains 1 with no fall_tick. A subsequent stable 0 produces the full 2^CNT_W filter.
- Parallel channels: sw[0] rises while sw[4] falls in the same cycle → rise_tick[0] and fall_tick[4] are asserted in the same cycle. Reset asserted mid-wait1 on any channel → no tick and immediate 0 outputs.
- Repeat (macro defined): sw[0] held 40 cycles → rep_tick[0] pulses at 8, 16, 24, 32 cycles after db_level rises. With the macro undefined → rep_tick stays 0.
